// File: rtl/uart_frame_loader_if.sv
// Bundle of the UART line and register-file write/status signals of the frame loader.
// The loader uses the slave view; whoever owns the UART line and consumes the strobes uses the master view.
interface uart_frame_loader_if;
  logic       rx;
  logic [7:0] read_data;
  logic [5:0] idx;
  logic       update_reg;
  logic       pc_ready;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  rx,
    output read_data, idx, update_reg, pc_ready, frame_err, busy
  );

  modport master (
    output rx,
    input  read_data, idx, update_reg, pc_ready, frame_err, busy
  );
endinterface

// File: rtl/uart_frame_loader.sv
// 8N1 UART receiver plus framer: hunts for a sync byte, streams the payload into the register file,
// and checks the trailing mod-256 checksum before signalling pc_ready.
module uart_frame_loader #(
  parameter int         CLK_HZ       = 25_000_000,
  parameter int         BAUD         = 115_200,
  parameter int         FRAME_BYTES  = 55,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_BITS = 32
) (
  input logic              clk,
  input logic              rst_n,
  uart_frame_loader_if.slave host
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
  localparam logic [5:0]       LAST_IDX  = 6'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bitState_t;
  typedef enum logic [1:0] {FR_HUNT, FR_PAYLOAD, FR_CHECK} frState_t;

  logic rxMeta_q, rxSync_q, rxPrev_q;

  bitState_t        bitState_q, bitState_d;
  logic [CNT_W-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byteOk, byteBad;

  frState_t         frState_q, frState_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic [TO_W-1:0]  toCnt_q, toCnt_d;
  logic [7:0]       readData_q, readData_d;
  logic [5:0]       idx_q, idx_d;
  logic             updateReg_q, updateReg_d;
  logic             pcReady_q, pcReady_d;
  logic             frameErr_q, frameErr_d;
  logic             busy_q, busy_d;
  logic             timedOut;

  // The line idles high, so the synchronizer and edge history also reset high to avoid a phantom start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= host.rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitState_q <= BIT_IDLE;
      clkCnt_q   <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
    end else begin
      bitState_q <= bitState_d;
      clkCnt_q   <= clkCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
    end
  end

  // byteOk/byteBad are combinational on the stop-bit sample so the framer's registered strobes land one clock later.
  always_comb begin
    bitState_d = bitState_q;
    clkCnt_d   = clkCnt_q + CNT_ONE;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    byteOk     = 1'b0;
    byteBad    = 1'b0;
    case (bitState_q)
      BIT_IDLE: begin
        clkCnt_d = '0;
        if (rxPrev_q && !rxSync_q) bitState_d = BIT_START;
      end
      BIT_START: begin
        if (clkCnt_q == HALF_LAST) begin
          clkCnt_d   = '0;
          bitIdx_d   = '0;
          bitState_d = rxSync_q ? BIT_IDLE : BIT_DATA;
        end
      end
      BIT_DATA: begin
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d = '0;
          shift_d  = {rxSync_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) bitState_d = BIT_STOP;
        end
      end
      BIT_STOP: begin
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d   = '0;
          byteOk     = rxSync_q;
          byteBad    = !rxSync_q;
          bitState_d = BIT_IDLE;
        end
      end
      default: bitState_d = BIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frState_q   <= FR_HUNT;
      cnt_q       <= '0;
      sum_q       <= '0;
      toCnt_q     <= '0;
      readData_q  <= '0;
      idx_q       <= '0;
      updateReg_q <= 1'b0;
      pcReady_q   <= 1'b0;
      frameErr_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frState_q   <= frState_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      toCnt_q     <= toCnt_d;
      readData_q  <= readData_d;
      idx_q       <= idx_d;
      updateReg_q <= updateReg_d;
      pcReady_q   <= pcReady_d;
      frameErr_q  <= frameErr_d;
      busy_q      <= busy_d;
    end
  end

  assign timedOut = (toCnt_q == TO_LAST);

  // Inside a frame a received byte always wins over a coincident timeout; otherwise a bad stop bit or
  // an idle gap of TIMEOUT_CLKS since the last good byte aborts back to HUNT.
  always_comb begin
    frState_d   = frState_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    toCnt_d     = toCnt_q;
    readData_d  = readData_q;
    idx_d       = idx_q;
    updateReg_d = 1'b0;
    pcReady_d   = 1'b0;
    frameErr_d  = 1'b0;
    busy_d      = busy_q;
    case (frState_q)
      FR_HUNT: begin
        toCnt_d = '0;
        if (byteOk && shift_q == SYNC_BYTE) begin
          cnt_d     = '0;
          sum_d     = '0;
          busy_d    = 1'b1;
          frState_d = FR_PAYLOAD;
        end
      end
      FR_PAYLOAD: begin
        if (byteOk) begin
          updateReg_d = 1'b1;
          idx_d       = cnt_q;
          readData_d  = shift_q;
          sum_d       = sum_q + shift_q;
          cnt_d       = cnt_q + 6'd1;
          toCnt_d     = '0;
          if (cnt_q == LAST_IDX) frState_d = FR_CHECK;
        end
      end
      FR_CHECK: begin
        if (byteOk) begin
          pcReady_d  = (shift_q == sum_q);
          frameErr_d = (shift_q != sum_q);
          busy_d     = 1'b0;
          cnt_d      = '0;
          toCnt_d    = '0;
          frState_d  = FR_HUNT;
        end
      end
      default: frState_d = FR_HUNT;
    endcase
    if (frState_q != FR_HUNT && !byteOk) begin
      if (byteBad || timedOut) begin
        frameErr_d = 1'b1;
        busy_d     = 1'b0;
        cnt_d      = '0;
        toCnt_d    = '0;
        frState_d  = FR_HUNT;
      end else begin
        toCnt_d = toCnt_q + TO_ONE;
      end
    end
  end

  assign host.read_data  = readData_q;
  assign host.idx        = idx_q;
  assign host.update_reg = updateReg_q;
  assign host.pc_ready   = pcReady_q;
  assign host.frame_err  = frameErr_q;
  assign host.busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: serialises 8N1 bytes onto rx and compares the observed
// strobe stream against a byte-level framing model, including exact latency and timeout instants.
module tb_uart_frame_loader;

  localparam int         CLK_HZ   = 921_600;
  localparam int         BAUD     = 115_200;
  localparam int         CPB      = CLK_HZ / BAUD;
  localparam int         FRAME    = 55;
  localparam int         TOB      = 32;
  localparam int         TO_CLKS  = TOB * CPB;
  localparam logic [7:0] SYNC     = 8'hA5;
  // Stop-bit middle is 9.5 bit times after the start edge, plus two synchronizer flops, plus the output register.
  localparam int         STROBE_LAT = 9 * CPB + CPB / 2 + 2 + 1;

  localparam int EV_UPD = 0;
  localparam int EV_PC  = 1;
  localparam int EV_ERR = 2;

  typedef struct {
    logic [7:0] v;
    bit         ok;
  } tx_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   compared   = 0;
  int   mismatched = 0;
  int   lastStart  = 0;
  int   obsQ[$];
  int   obsCyc[$];
  int   expQ[$];

  uart_frame_loader_if busIf ();

  uart_frame_loader #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .FRAME_BYTES (FRAME),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .host (busIf.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int enc(input int kind, input int i, input int d);
    return kind * 65536 + i * 256 + d;
  endfunction

  function automatic tx_t mkTx(input int v, input bit ok);
    tx_t t;
    t.v  = 8'(v);
    t.ok = ok;
    return t;
  endfunction

  // Record every strobe with the cycle it was seen in.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busIf.update_reg) begin
        obsQ.push_back(enc(EV_UPD, int'(busIf.idx), int'(busIf.read_data)));
        obsCyc.push_back(cyc);
      end
      if (busIf.pc_ready) begin
        obsQ.push_back(enc(EV_PC, 0, 0));
        obsCyc.push_back(cyc);
      end
      if (busIf.frame_err) begin
        obsQ.push_back(enc(EV_ERR, 0, 0));
        obsCyc.push_back(cyc);
      end
    end
  end

  // Byte-level framing rules: what the register file and status lines should see for a byte sequence.
  function automatic void modelFrames(input tx_t txs[$]);
    bit inFrame = 1'b0;
    int n = 0;
    int sum = 0;
    foreach (txs[i]) begin
      if (!inFrame) begin
        if (txs[i].ok && txs[i].v == SYNC) begin
          inFrame = 1'b1;
          n = 0;
          sum = 0;
        end
      end else if (!txs[i].ok) begin
        expQ.push_back(enc(EV_ERR, 0, 0));
        inFrame = 1'b0;
      end else if (n < FRAME) begin
        expQ.push_back(enc(EV_UPD, n, int'(txs[i].v)));
        sum = (sum + int'(txs[i].v)) % 256;
        n++;
      end else begin
        expQ.push_back(enc(int'(txs[i].v) == sum ? EV_PC : EV_ERR, 0, 0));
        inFrame = 1'b0;
      end
    end
  endfunction

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; leaves the line idle at posedge+1 right after the stop bit.
  task automatic sendByte(input logic [7:0] v, input bit stopOk);
    lastStart = cyc;
    busIf.rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int b = 0; b < 8; b++) begin
      busIf.rx = v[b];
      repeat (CPB) @(posedge clk);
      #1;
    end
    busIf.rx = stopOk;
    repeat (CPB) @(posedge clk);
    #1;
    busIf.rx = 1'b1;
  endtask

  // A broken stop bit leaves the line low, so give it time to return high before the next start bit.
  task automatic sendList(input tx_t txs[$], input int maxGap);
    foreach (txs[i]) begin
      sendByte(txs[i].v, txs[i].ok);
      if (!txs[i].ok) idle(2 * CPB);
      else if (maxGap > 0) idle($urandom_range(0, maxGap));
    end
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    busIf.rx = 1'b1;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 busIf.rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      outs = {busIf.update_reg, busIf.pc_ready, busIf.frame_err, busIf.busy, busIf.idx, busIf.read_data};
      compared++;
      if (outs !== 18'h0) begin
        mismatched++;
        $display("[TB] FAIL reset_hold cycle %0d: outputs %h, expected 0", i, outs);
      end
    end
    @(posedge clk);
    #1 busIf.rx = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(40);
    outs = {busIf.update_reg, busIf.pc_ready, busIf.frame_err, busIf.busy, busIf.idx, busIf.read_data};
    compared++;
    if (outs !== 18'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_release: outputs %h, expected 0", outs);
    end
    compared++;
    if (obsQ.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL reset_strobes: %0d strobes seen, expected 0", obsQ.size());
    end
  endtask

  task automatic test_good_frame();
    tx_t txs[$];
    int base, got;
    base = obsQ.size();
    expQ.delete();
    txs.push_back(mkTx(SYNC, 1'b1));
    for (int i = 0; i < FRAME; i++) txs.push_back(mkTx(i, 1'b1));
    txs.push_back(mkTx(8'hCD, 1'b1));
    sendByte(SYNC, 1'b1);
    compared++;
    if (busIf.busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL good_busy_after_sync: busy %b, expected 1", busIf.busy);
    end
    for (int i = 1; i < txs.size(); i++) sendByte(txs[i].v, txs[i].ok);
    idle(20);
    modelFrames(txs);
    for (int i = 0; i < expQ.size(); i++) begin
      got = (base + i < obsQ.size()) ? obsQ[base + i] : -1;
      compared++;
      if (got !== expQ[i]) begin
        mismatched++;
        $display("[TB] FAIL good_frame event %0d: got %h, expected %h", i, got, expQ[i]);
      end
    end
    compared++;
    if (obsQ.size() - base !== expQ.size()) begin
      mismatched++;
      $display("[TB] FAIL good_frame count: got %0d events, expected %0d", obsQ.size() - base, expQ.size());
    end
    compared++;
    if (obsQ.size() <= base || obsCyc[obsCyc.size() - 1] !== lastStart + STROBE_LAT) begin
      mismatched++;
      $display("[TB] FAIL good_pc_latency: last strobe cycle %0d, expected %0d",
               (obsQ.size() > base) ? obsCyc[obsCyc.size() - 1] : -1, lastStart + STROBE_LAT);
    end
    for (int i = base + 1; i < obsQ.size(); i++) begin
      compared++;
      if (obsCyc[i] == obsCyc[i - 1] || (obsCyc[i] == obsCyc[i - 1] + 1 && obsQ[i] / 65536 == obsQ[i - 1] / 65536)) begin
        mismatched++;
        $display("[TB] FAIL good_strobe_spacing at event %0d: cycles %0d and %0d", i - base, obsCyc[i - 1], obsCyc[i]);
      end
    end
    compared++;
    if (busIf.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL good_busy_end: busy %b, expected 0", busIf.busy);
    end
  endtask

  task automatic test_bad_checksum();
    tx_t txs[$];
    int base, got;
    base = obsQ.size();
    expQ.delete();
    txs.push_back(mkTx(SYNC, 1'b1));
    for (int i = 0; i < FRAME; i++) txs.push_back(mkTx(i, 1'b1));
    txs.push_back(mkTx(8'hCE, 1'b1));
    sendList(txs, 0);
    idle(20);
    modelFrames(txs);
    for (int i = 0; i < expQ.size(); i++) begin
      got = (base + i < obsQ.size()) ? obsQ[base + i] : -1;
      compared++;
      if (got !== expQ[i]) begin
        mismatched++;
        $display("[TB] FAIL bad_checksum event %0d: got %h, expected %h", i, got, expQ[i]);
      end
    end
    compared++;
    if (obsQ.size() - base !== expQ.size()) begin
      mismatched++;
      $display("[TB] FAIL bad_checksum count: got %0d events, expected %0d", obsQ.size() - base, expQ.size());
    end
    compared++;
    if (busIf.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bad_checksum_busy: busy %b, expected 0", busIf.busy);
    end
  endtask

  task automatic test_noise_then_frame();
    tx_t txs[$];
    int base, got;
    base = obsQ.size();
    expQ.delete();
    txs.push_back(mkTx(8'h12, 1'b1));
    txs.push_back(mkTx(8'h34, 1'b1));
    sendList(txs, 0);
    busIf.rx = 1'b0;
    idle(3);
    busIf.rx = 1'b1;
    idle(20);
    compared++;
    if (obsQ.size() !== base || busIf.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL noise_quiet: %0d strobes, busy %b, expected 0 and 0", obsQ.size() - base, busIf.busy);
    end
    txs.delete();
    txs.push_back(mkTx(SYNC, 1'b1));
    for (int i = 0; i < FRAME; i++) txs.push_back(mkTx(i, 1'b1));
    txs.push_back(mkTx(8'hCD, 1'b1));
    sendList(txs, 0);
    idle(20);
    modelFrames(txs);
    for (int i = 0; i < expQ.size(); i++) begin
      got = (base + i < obsQ.size()) ? obsQ[base + i] : -1;
      compared++;
      if (got !== expQ[i]) begin
        mismatched++;
        $display("[TB] FAIL noise_frame event %0d: got %h, expected %h", i, got, expQ[i]);
      end
    end
    compared++;
    if (obsQ.size() - base !== expQ.size()) begin
      mismatched++;
      $display("[TB] FAIL noise_frame count: got %0d events, expected %0d", obsQ.size() - base, expQ.size());
    end
  endtask

  task automatic test_stop_error();
    tx_t txs[$];
    int base, got;
    base = obsQ.size();
    expQ.delete();
    txs.push_back(mkTx(SYNC, 1'b1));
    for (int i = 0; i < FRAME; i++) txs.push_back(mkTx(i, i != 10));
    txs.push_back(mkTx(8'hCD, 1'b1));
    txs.push_back(mkTx(SYNC, 1'b1));
    for (int i = 0; i < FRAME; i++) txs.push_back(mkTx(i, 1'b1));
    txs.push_back(mkTx(8'hCD, 1'b1));
    sendList(txs, 0);
    idle(20);
    modelFrames(txs);
    for (int i = 0; i < expQ.size(); i++) begin
      got = (base + i < obsQ.size()) ? obsQ[base + i] : -1;
      compared++;
      if (got !== expQ[i]) begin
        mismatched++;
        $display("[TB] FAIL stop_error event %0d: got %h, expected %h", i, got, expQ[i]);
      end
    end
    compared++;
    if (obsQ.size() - base !== expQ.size()) begin
      mismatched++;
      $display("[TB] FAIL stop_error count: got %0d events, expected %0d", obsQ.size() - base, expQ.size());
    end
  endtask

  task automatic test_timeout();
    tx_t txs[$];
    int base, got, errCyc;
    base = obsQ.size();
    expQ.delete();
    txs.push_back(mkTx(SYNC, 1'b1));
    for (int i = 0; i < 20; i++) txs.push_back(mkTx($urandom_range(0, 255), 1'b1));
    sendList(txs, 0);
    idle(TO_CLKS + 40);
    modelFrames(txs);
    expQ.push_back(enc(EV_ERR, 0, 0));
    for (int i = 0; i < expQ.size(); i++) begin
      got = (base + i < obsQ.size()) ? obsQ[base + i] : -1;
      compared++;
      if (got !== expQ[i]) begin
        mismatched++;
        $display("[TB] FAIL timeout event %0d: got %h, expected %h", i, got, expQ[i]);
      end
    end
    compared++;
    if (obsQ.size() - base !== expQ.size()) begin
      mismatched++;
      $display("[TB] FAIL timeout count: got %0d events, expected %0d", obsQ.size() - base, expQ.size());
    end
    errCyc = (obsQ.size() > base) ? obsCyc[obsCyc.size() - 1] : -1;
    compared++;
    if (errCyc !== lastStart + STROBE_LAT + TO_CLKS) begin
      mismatched++;
      $display("[TB] FAIL timeout_instant: frame_err at cycle %0d, expected %0d", errCyc, lastStart + STROBE_LAT + TO_CLKS);
    end
    compared++;
    if (busIf.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_busy: busy %b, expected 0", busIf.busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    tx_t txs[$];
    logic [17:0] outs;
    int base, pcSeen;
    base = obsQ.size();
    txs.push_back(mkTx(SYNC, 1'b1));
    for (int i = 0; i < FRAME; i++) txs.push_back(mkTx(i, 1'b1));
    txs.push_back(mkTx(8'hCD, 1'b1));
    fork
      sendList(txs, 0);
      begin
        repeat (10 * CPB * 8 + 37) @(posedge clk);
        #3;
        compared++;
        if (busIf.busy !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL midreset_busy_before: busy %b, expected 1", busIf.busy);
        end
        rst_n = 1'b0;
        #1;
        outs = {busIf.update_reg, busIf.pc_ready, busIf.frame_err, busIf.busy, busIf.idx, busIf.read_data};
        compared++;
        if (outs !== 18'h0) begin
          mismatched++;
          $display("[TB] FAIL midreset_outputs: outputs %h, expected 0", outs);
        end
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
      end
    join
    idle(100);
    pcSeen = 0;
    for (int i = base; i < obsQ.size(); i++) if (obsQ[i] == enc(EV_PC, 0, 0)) pcSeen++;
    compared++;
    if (pcSeen !== 0) begin
      mismatched++;
      $display("[TB] FAIL midreset_no_pc: %0d pc_ready pulses, expected 0", pcSeen);
    end
  endtask

  task automatic test_random_frames();
    tx_t txs[$];
    int base, got, sum, badPos, v;
    for (int f = 0; f < 3; f++) begin
      base = obsQ.size();
      expQ.delete();
      txs.delete();
      for (int n = $urandom_range(0, 3); n > 0; n--) begin
        v = $urandom_range(0, 255);
        txs.push_back(mkTx((v == SYNC) ? 8'h5A : v, $urandom_range(0, 3) != 0));
      end
      txs.push_back(mkTx(SYNC, 1'b1));
      badPos = ($urandom_range(0, 2) == 0) ? $urandom_range(0, FRAME - 1) : -1;
      sum = 0;
      for (int i = 0; i < FRAME; i++) begin
        v = $urandom_range(0, 255);
        if (v == SYNC) v = 8'h5A;
        txs.push_back(mkTx(v, i != badPos));
        sum = (sum + v) % 256;
        if (i == badPos) break;
      end
      if (badPos < 0) txs.push_back(mkTx(($urandom_range(0, 1) == 0) ? sum : (sum + 1) % 256, 1'b1));
      sendList(txs, 16);
      idle(30);
      modelFrames(txs);
      for (int i = 0; i < expQ.size(); i++) begin
        got = (base + i < obsQ.size()) ? obsQ[base + i] : -1;
        compared++;
        if (got !== expQ[i]) begin
          mismatched++;
          $display("[TB] FAIL random_frame%0d event %0d: got %h, expected %h", f, i, got, expQ[i]);
        end
      end
      compared++;
      if (obsQ.size() - base !== expQ.size()) begin
        mismatched++;
        $display("[TB] FAIL random_frame%0d count: got %0d events, expected %0d", f, obsQ.size() - base, expQ.size());
      end
    end
  endtask

  initial begin
    busIf.rx = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_noise_then_frame();
    test_stop_error();
    test_timeout();
    test_random_frames();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
